// File: rtl/data_skew_pkg.sv
// data_skew_pkg
//   Shared types and helpers for the data_skew_stage slice.
//   - skew_state_e : drain FSM state encoding (IDLE, RUN, DRAIN)
//   - lane_delay() : per-lane delay D_i in cycles, for skew or deskew direction
//   - cnt_width()  : width of the drain counter, never narrower than 1 bit
package data_skew_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } skew_state_e;

  // Skew: lane 0 is undelayed and delays grow with the lane index.
  // Deskew: the last lane is undelayed, so the two modes undo each other.
  function automatic int lane_delay(input int i, input int data_num,
                                    input int skew_step, input int reverse);
    return (reverse != 0) ? (data_num - 1 - i) * skew_step : i * skew_step;
  endfunction

  function automatic int cnt_width(input int max_dly);
    return (max_dly < 1) ? 1 : $clog2(max_dly + 1);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line
//   DEPTH-stage shift register carrying a {valid, data} pair.
//   DEPTH = 0 degenerates to a plain wire (no registers).
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset, clears every stage
//   en_i     in   advance enable; 0 holds every stage
//   flush_i  in   synchronous clear of every stage, wins over en_i
//   valid_i  in   valid entering stage 0
//   data_i   in   WIDTH-bit data entering stage 0
//   valid_o  out  valid leaving the last stage
//   data_o   out  data leaving the last stage
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_wire
    // Clock and control inputs have no effect on a wire-through lane.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, en_i, flush_i};
    assign valid_o     = valid_i;
    assign data_o      = data_i;
  end else begin : g_chain
    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int k = 0; k < DEPTH; k++) dat_q[k] <= '0;
      end else if (flush_i) begin
        vld_q <= '0;
        for (int k = 0; k < DEPTH; k++) dat_q[k] <= '0;
      end else if (en_i) begin
        vld_q[0] <= valid_i;
        dat_q[0] <= data_i;
        for (int k = 1; k < DEPTH; k++) begin
          vld_q[k] <= vld_q[k-1];
          dat_q[k] <= dat_q[k-1];
        end
      end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = dat_q[DEPTH-1];
  end

endmodule

// File: rtl/data_skew_stage.sv
// data_skew_stage
//   Delays lane i of a DATA_NUM-wide vector by D_i cycles so a systolic array
//   sees a staircase at its edge (REVERSE=0), or re-aligns a staircase coming
//   out of the array (REVERSE=1). Tracks per-lane valid, supports stall and
//   flush, and runs a drain FSM that pulses drain_done_o once the last vector
//   (marked by calc_done_i) has left the longest chain.
//
//   Optional build macro DATA_SKEW_ZERO_FILL_EN: when defined, data_out[i] is
//   forced to zero whenever lane_valid_o[i] is low (including the undelayed
//   lane). When undefined, data_out carries the raw shifted value and the
//   consumer must qualify it with lane_valid_o.
//
// Ports:
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   en_i           in   advance enable; 0 stalls every register and the FSM
//   flush_i        in   synchronous clear of chains and FSM, wins over en_i
//   data_in        in   DATA_NUM lanes of DATA_WIDTH bits
//   input_valid_i  in   vector valid
//   calc_done_i    in   last-vector marker
//   data_out       out  skewed lanes
//   lane_valid_o   out  per-lane valid aligned with data_out[i]
//   input_valid_o  out  input_valid_i delayed by MAX_DLY
//   calc_done_o    out  calc_done_i delayed by MAX_DLY
//   busy_o         out  FSM not idle or any lane still valid
//   drain_done_o   out  one-cycle pulse on the last DRAIN cycle
module data_skew_stage
  import data_skew_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_NUM   = 4,
  parameter int SKEW_STEP  = 1,
  parameter int REVERSE    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_in [0:DATA_NUM-1],
  input  logic                  input_valid_i,
  input  logic                  calc_done_i,
  output logic [DATA_WIDTH-1:0] data_out [0:DATA_NUM-1],
  output logic [DATA_NUM-1:0]   lane_valid_o,
  output logic                  input_valid_o,
  output logic                  calc_done_o,
  output logic                  busy_o,
  output logic                  drain_done_o
);

  localparam int               MAX_DLY  = (DATA_NUM - 1) * SKEW_STEP;
  localparam int               CNT_W    = cnt_width(MAX_DLY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MAX_DLY);

  logic [DATA_WIDTH-1:0] lane_data [0:DATA_NUM-1];
  logic [DATA_NUM-1:0]   lane_vld;

  for (genvar i = 0; i < DATA_NUM; i++) begin : g_lane
    localparam int D = lane_delay(i, DATA_NUM, SKEW_STEP, REVERSE);
    logic vld_raw;

    skew_delay_line #(
      .DEPTH (D),
      .WIDTH (DATA_WIDTH)
    ) u_line (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en_i),
      .flush_i (flush_i),
      .valid_i (input_valid_i),
      .data_i  (data_in[i]),
      .valid_o (vld_raw),
      .data_o  (lane_data[i])
    );

    // The undelayed lane is a wire, so a vector presented during a stall is
    // not accepted and must not be reported as valid on that lane.
    if (D == 0) begin : g_pass
      assign lane_vld[i] = vld_raw & en_i;
    end else begin : g_reg
      assign lane_vld[i] = vld_raw;
    end

`ifdef DATA_SKEW_ZERO_FILL_EN
    assign data_out[i] = lane_vld[i] ? lane_data[i] : '0;
`else
    assign data_out[i] = lane_data[i];
`endif
  end

  assign lane_valid_o = lane_vld;

  // Both control markers share one MAX_DLY-deep chain: valid rides the
  // valid bit, calc_done rides the 1-bit data field.
  skew_delay_line #(
    .DEPTH (MAX_DLY),
    .WIDTH (1)
  ) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en_i),
    .flush_i (flush_i),
    .valid_i (input_valid_i),
    .data_i  (calc_done_i),
    .valid_o (input_valid_o),
    .data_o  (calc_done_o)
  );

  skew_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain_done;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drain_done = 1'b0;
    if (en_i) begin
      unique case (state_q)
        IDLE: begin
          if (calc_done_i) begin
            state_d = DRAIN;
            cnt_d   = CNT_LOAD;
          end else if (input_valid_i) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (calc_done_i) begin
            state_d = DRAIN;
            cnt_d   = CNT_LOAD;
          end
        end
        DRAIN: begin
          // A further calc_done_i here only travels down the control chain.
          if (cnt_q == '0) begin
            state_d    = IDLE;
            drain_done = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Flush abandons a drain silently.
    if (flush_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      drain_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign drain_done_o = drain_done;
  assign busy_o       = (state_q != IDLE) | (|lane_vld);

endmodule

// File: tb/tb_data_skew_stage.sv
module tb_data_skew_stage;
  import data_skew_pkg::*;

  localparam int DW = 8;
  localparam int DN = 4;

`ifdef DATA_SKEW_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  // Expected lane_valid patterns per cycle (bit i = lane i).
  localparam logic [3:0] T1_A [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                      4'b0000, 4'b0000, 4'b0000, 4'b0000};
  localparam logic [3:0] T1_B [8] = '{4'b1000, 4'b0000, 4'b0100, 4'b0000,
                                      4'b0010, 4'b0000, 4'b0001, 4'b0000};
  localparam logic [3:0] T4_A [7] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010,
                                      4'b0100, 4'b1000, 4'b0000};
  localparam logic [7:0] T6_IN [7] = '{8'h11, 8'h22, 8'h33, 8'hFF,
                                       8'h00, 8'h00, 8'h00};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, en, flush, vin, cdin;
  logic [DW-1:0] din    [0:DN-1];
  logic [DW-1:0] dout_a [0:DN-1];
  logic [DW-1:0] dout_b [0:DN-1];
  logic [DN-1:0] lv_a, lv_b;
  logic          ivo_a, cdo_a, busy_a, dd_a;
  logic          ivo_b, cdo_b, busy_b, dd_b;

  int n_tests = 0;
  int n_fail  = 0;

  data_skew_stage #(
    .DATA_WIDTH (DW), .DATA_NUM (DN), .SKEW_STEP (1), .REVERSE (0)
  ) u_a (
    .clk (clk), .rst_n (rst_n), .en_i (en), .flush_i (flush),
    .data_in (din), .input_valid_i (vin), .calc_done_i (cdin),
    .data_out (dout_a), .lane_valid_o (lv_a), .input_valid_o (ivo_a),
    .calc_done_o (cdo_a), .busy_o (busy_a), .drain_done_o (dd_a)
  );

  data_skew_stage #(
    .DATA_WIDTH (DW), .DATA_NUM (DN), .SKEW_STEP (2), .REVERSE (1)
  ) u_b (
    .clk (clk), .rst_n (rst_n), .en_i (en), .flush_i (flush),
    .data_in (din), .input_valid_i (vin), .calc_done_i (cdin),
    .data_out (dout_b), .lane_valid_o (lv_b), .input_valid_o (ivo_b),
    .calc_done_o (cdo_b), .busy_o (busy_b), .drain_done_o (dd_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_vec(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    din[0] = a; din[1] = b; din[2] = c; din[3] = d;
  endtask

  task automatic set_all(input logic [7:0] v);
    set_vec(v, v, v, v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Pulses the async reset mid-cycle; returns inside a fresh cycle (c0).
  task automatic do_reset();
    @(posedge clk);
    #1;
    en = 1'b1; flush = 1'b0; vin = 1'b0; cdin = 1'b0; set_all(8'h00);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; vin = 1'b0; cdin = 1'b0;
    set_all(8'h00);

    // Reset state
    @(negedge clk);
    chk("rst lv_a", lv_a, 0);
    chk("rst lv_b", lv_b, 0);
    chk("rst ivo_a", ivo_a, 0);
    chk("rst cdo_a", cdo_a, 0);
    chk("rst busy_a", busy_a, 0);
    chk("rst dd_a", dd_a, 0);
    chk("rst dout_a3", dout_a[3], 0);
    chk("rst busy_b", busy_b, 0);
    chk("rst ivo_b", ivo_b, 0);

    chk("lane_delay skew", lane_delay(3, 4, 1, 0), 3);
    chk("lane_delay deskew", lane_delay(0, 4, 2, 1), 6);

    // Staircase in both directions from one vector
    do_reset();
    set_vec(8'd10, 8'd20, 8'd30, 8'd40); vin = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("t1 lv_a c%0d", c), lv_a, T1_A[c]);
      chk($sformatf("t1 lv_b c%0d", c), lv_b, T1_B[c]);
      chk($sformatf("t1 ivo_a c%0d", c), ivo_a, (c == 3));
      chk($sformatf("t1 ivo_b c%0d", c), ivo_b, (c == 6));
      for (int k = 0; k < DN; k++) begin
        if (T1_A[c][k]) chk($sformatf("t1 dout_a%0d c%0d", k, c), dout_a[k], 10 * (k + 1));
        if (T1_B[c][k]) chk($sformatf("t1 dout_b%0d c%0d", k, c), dout_b[k], 10 * (k + 1));
      end
      next_cycle();
      vin = 1'b0; set_all(8'h00);
    end

    // Five vectors, last one marked done: drain timing
    do_reset();
    for (int c = 0; c < 10; c++) begin
      vin  = (c < 5);
      cdin = (c == 4);
      if (c < 5) set_all(8'(c + 1)); else set_all(8'h00);
      @(negedge clk);
      chk($sformatf("t3 ivo c%0d", c), ivo_a, (c >= 3 && c <= 7));
      chk($sformatf("t3 cdo c%0d", c), cdo_a, (c == 7));
      if (c >= 5) chk($sformatf("t3 dd c%0d", c), dd_a, (c == 8));
      if (c >= 5) chk($sformatf("t3 busy c%0d", c), busy_a, (c != 9));
      if (c == 7) chk("t3 lv c7", lv_a, 4'b1000);
      next_cycle();
    end
    vin = 1'b0; cdin = 1'b0;

    // Two-cycle stall mid-ramp
    do_reset();
    set_vec(8'd10, 8'd20, 8'd30, 8'd40);
    for (int c = 0; c < 7; c++) begin
      vin = (c == 0);
      en  = !(c == 1 || c == 2);
      @(negedge clk);
      chk($sformatf("t4 lv c%0d", c), lv_a, T4_A[c]);
      chk($sformatf("t4 ivo c%0d", c), ivo_a, (c == 5));
      for (int k = 1; k < DN; k++)
        if (T4_A[c][k]) chk($sformatf("t4 dout%0d c%0d", k, c), dout_a[k], 10 * (k + 1));
      next_cycle();
    end
    en = 1'b1; vin = 1'b0;

    // Stall during DRAIN does not consume the count
    do_reset();
    for (int c = 0; c < 8; c++) begin
      vin  = (c == 0);
      cdin = (c == 0);
      en   = !(c == 2 || c == 3);
      @(negedge clk);
      if (c >= 1) chk($sformatf("t4d dd c%0d", c), dd_a, (c == 6));
      chk($sformatf("t4d cdo c%0d", c), cdo_a, (c == 5));
      if (c == 7) chk("t4d busy c7", busy_a, 0);
      next_cycle();
    end
    en = 1'b1; vin = 1'b0; cdin = 1'b0;

    // Flush during DRAIN with cnt=2
    do_reset();
    set_vec(8'd10, 8'd20, 8'd30, 8'd40);
    for (int c = 0; c < 6; c++) begin
      vin   = (c == 0);
      cdin  = (c == 0);
      flush = (c == 2);
      @(negedge clk);
      if (c == 2) chk("t5 lv c2", lv_a, 4'b0100);
      if (c == 2) chk("t5 busy c2", busy_a, 1);
      if (c >= 3) chk($sformatf("t5 lv c%0d", c), lv_a, 0);
      if (c >= 3) chk($sformatf("t5 busy c%0d", c), busy_a, 0);
      if (c >= 3) chk($sformatf("t5 cdo c%0d", c), cdo_a, 0);
      if (c >= 1) chk($sformatf("t5 dd c%0d", c), dd_a, 0);
      next_cycle();
    end
    flush = 1'b0; vin = 1'b0; cdin = 1'b0;

    // Same point, async reset instead of flush
    do_reset();
    for (int c = 0; c < 6; c++) begin
      vin  = (c == 0);
      cdin = (c == 0);
      @(negedge clk);
      if (c == 2) begin
        chk("t5r lv before", lv_a, 4'b0100);
        #1 rst_n = 1'b0;
        #1;
        chk("t5r lv in rst", lv_a, 0);
        chk("t5r busy in rst", busy_a, 0);
        chk("t5r dd in rst", dd_a, 0);
        #1 rst_n = 1'b1;
      end
      if (c >= 3) begin
        chk($sformatf("t5r lv c%0d", c), lv_a, 0);
        chk($sformatf("t5r busy c%0d", c), busy_a, 0);
        chk($sformatf("t5r cdo c%0d", c), cdo_a, 0);
        chk($sformatf("t5r dd c%0d", c), dd_a, 0);
      end
      next_cycle();
    end
    vin = 1'b0; cdin = 1'b0;

    // Ramp triangle contents: stale data unless zero fill is built in
    do_reset();
    for (int c = 0; c < 7; c++) begin
      set_all(T6_IN[c]);
      vin = (c == 3);
      @(negedge clk);
      if (c == 2) chk("t6 dout0 c2", dout_a[0], ZF ? 8'h00 : 8'h33);
      if (c == 3) chk("t6 dout3 c3", dout_a[3], ZF ? 8'h00 : 8'h11);
      if (c == 4) chk("t6 dout3 c4", dout_a[3], ZF ? 8'h00 : 8'h22);
      if (c == 5) chk("t6 dout3 c5", dout_a[3], ZF ? 8'h00 : 8'h33);
      if (c == 6) chk("t6 dout3 c6", dout_a[3], 8'hFF);
      if (c == 6) chk("t6 lv c6", lv_a, 4'b1000);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
